// File: rtl/tri_scan_raster_pkg.sv
// Shared types and constants for the triangle scan rasterizer.
package raster_pkg;

  localparam int W         = 16;
  localparam int FRAC_BITS = 6;
  localparam int EW        = 36;
  localparam int PIX_STEP  = 64;

  typedef enum logic [1:0] {StIdle, StSetup, StScan} state_e;

  typedef logic signed [EW-1:0] edge_t;
  typedef logic signed [W:0]    diff_t;

  function automatic diff_t sdiff(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return {a[W-1], a} - {b[W-1], b};
  endfunction

  function automatic edge_t ext(input diff_t a);
    return {{(EW-W-1){a[W]}}, a};
  endfunction

  function automatic edge_t emul(input diff_t a, input diff_t b);
    return ext(a) * ext(b);
  endfunction

endpackage

// File: rtl/tri_scan_raster_if.sv
// Triangle input and fragment output handshake bundle for tri_scan_raster.
interface tri_scan_raster_if;
  import raster_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic signed [W-1:0] xmin, xmax, ymin, ymax;
  logic                frag_valid;
  logic                frag_ready;
  logic signed [W-1:0] frag_x, frag_y;
  logic                tri_done;
  logic                busy;

  modport slave (
    input  in_valid, v0x, v0y, v1x, v1y, v2x, v2y, xmin, xmax, ymin, ymax, frag_ready,
    output in_ready, frag_valid, frag_x, frag_y, tri_done, busy
  );

  modport master (
    output in_valid, v0x, v0y, v1x, v1y, v2x, v2y, xmin, xmax, ymin, ymax, frag_ready,
    input  in_ready, frag_valid, frag_x, frag_y, tri_done, busy
  );

endinterface

// File: rtl/tri_scan_raster_edge_stepper.sv
// One incrementally stepped edge function: current value plus row-start value.
module edge_stepper
  import raster_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  edge_t i_init,
  input  edge_t i_dx,
  input  edge_t i_dy,
  input  logic  i_step_x,
  input  logic  i_step_row,
  output edge_t o_e
);

  edge_t r_e, r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e   <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_e   <= i_init;
      r_row <= i_init;
    end else if (i_step_row) begin
      r_e   <= r_row + i_dy;
      r_row <= r_row + i_dy;
    end else if (i_step_x) begin
      r_e   <= r_e + i_dx;
    end
  end

  assign o_e = r_e;

endmodule

// File: rtl/tri_scan_raster.sv
// Walks the bounding box row-major and emits fragments inside the triangle.
// Optional BACKFACE_CULL_EN: drop negative-area triangles during setup.
module tri_scan_raster
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  tri_scan_raster_if.slave   bus
);

  state_e              r_state, w_state_d;
  logic signed [W-1:0] r_vx [3];
  logic signed [W-1:0] r_vy [3];
  logic signed [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_cx, r_cy;
  logic                r_neg, r_tri_done;

  diff_t w_ddx [3];
  diff_t w_ddy [3];
  edge_t w_init [3];
  edge_t w_dx [3];
  edge_t w_dy [3];
  edge_t w_e [3];
  edge_t w_area;
  logic  w_load, w_step_x, w_step_row, w_done_d, w_inside, w_adv;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ddx[i]  = sdiff(r_vx[(i == 2) ? 0 : i + 1], r_vx[i]);
      w_ddy[i]  = sdiff(r_vy[(i == 2) ? 0 : i + 1], r_vy[i]);
      w_init[i] = emul(sdiff(r_xmin, r_vx[i]), w_ddy[i]) - emul(sdiff(r_ymin, r_vy[i]), w_ddx[i]);
      w_dx[i]   = ext(w_ddy[i]) <<< FRAC_BITS;
      w_dy[i]   = -(ext(w_ddx[i]) <<< FRAC_BITS);
    end
    w_area = emul(w_ddx[0], sdiff(r_vy[2], r_vy[0])) - emul(w_ddy[0], sdiff(r_vx[2], r_vx[0]));
  end

  for (genvar g = 0; g < 3; g++) begin : g_edge
    edge_stepper u_edge (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_init     (w_init[g]),
      .i_dx       (w_dx[g]),
      .i_dy       (w_dy[g]),
      .i_step_x   (w_step_x),
      .i_step_row (w_step_row),
      .o_e        (w_e[g])
    );
  end

  // Edge values are non-positive on the interior of a positive-area winding.
  assign w_inside = r_neg ? (!w_e[0][EW-1] && !w_e[1][EW-1] && !w_e[2][EW-1])
                          : ((w_e[0] <= 0) && (w_e[1] <= 0) && (w_e[2] <= 0));
  assign w_adv    = (r_state == StScan) && (!w_inside || bus.frag_ready);

  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_step_x   = 1'b0;
    w_step_row = 1'b0;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: if (bus.in_valid) w_state_d = StSetup;
      StSetup: begin
        w_load = 1'b1;
        if (w_area == '0) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
`ifdef BACKFACE_CULL_EN
        end else if (w_area[EW-1]) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
`endif
        end else begin
          w_state_d = StScan;
        end
      end
      StScan: begin
        if (w_adv) begin
          if (r_cx != r_xmax) begin
            w_step_x = 1'b1;
          end else if (r_cy != r_ymax) begin
            w_step_row = 1'b1;
          end else begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_tri_done <= 1'b0;
      r_neg      <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymin     <= '0;
      r_ymax     <= '0;
      for (int i = 0; i < 3; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
      end
    end else begin
      r_state    <= w_state_d;
      r_tri_done <= w_done_d;
      if (r_state == StIdle && bus.in_valid) begin
        r_vx[0] <= bus.v0x;
        r_vy[0] <= bus.v0y;
        r_vx[1] <= bus.v1x;
        r_vy[1] <= bus.v1y;
        r_vx[2] <= bus.v2x;
        r_vy[2] <= bus.v2y;
        r_xmin  <= bus.xmin;
        r_xmax  <= bus.xmax;
        r_ymin  <= bus.ymin;
        r_ymax  <= bus.ymax;
      end
      if (w_load) begin
        r_cx  <= r_xmin;
        r_cy  <= r_ymin;
        r_neg <= w_area[EW-1];
      end else if (w_step_row) begin
        r_cx <= r_xmin;
        r_cy <= r_cy + W'(PIX_STEP);
      end else if (w_step_x) begin
        r_cx <= r_cx + W'(PIX_STEP);
      end
    end
  end

  assign bus.in_ready   = (r_state == StIdle);
  assign bus.busy       = (r_state != StIdle);
  assign bus.frag_valid = (r_state == StScan) && w_inside;
  assign bus.frag_x     = r_cx;
  assign bus.frag_y     = r_cy;
  assign bus.tri_done   = r_tri_done;

endmodule
